timer_irq_ctrl: RTL
===================

Name: timer_irq_ctrl

Overview:
Interrupt controller that sits directly downstream of the Timer. It takes the Timer's PWM output bits (pwm1out, pwm2out) as event sources, captures their rising edges into pending flags, and masks them. It raises a single interrupt request to the multicycle core, which the core services over the same chipSelect/read/write/addr peripheral bus the Timer uses, through a claim/complete handshake.

Parameters:
NUM_SRC, 4, number of event sources (default: pwm1out[1:0] and pwm2out[1:0] concatenated as {pwm2out, pwm1out}).
ID_W, 3, width of the source id field; must satisfy 2^ID_W > NUM_SRC.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-low.
chipSelect  in  1  bus select; read and write are ignored when low.
write  in  1  bus write strobe; one access per cycle.
read  in  1  bus read strobe.
addr  in  5  word register index.
writeData  in  32  bus write data.
src  in  NUM_SRC  event inputs, level signals from the Timer.
readData  out  32  registered read data.
irq  out  1  registered interrupt request to the core.

Behaviour:
- Reset (rst=0 at a clk edge) clears all registers, readData, irq, state and the src history. After reset, irq=0 and readData=0 from the next cycle on. Reset asserted mid-service aborts service; no complete is needed afterwards.
- Edge detect: prev_src is registered every cycle. edge[i] = src[i] & ~prev_src[i]. After reset, prev_src=0, so a source that is already high produces an edge on the first active cycle.
- Register map (addr):
  - 0 CTRL: bit0 = global enable (gen), R/W.
  - 1 ENABLE: [NUM_SRC-1:0] mask, R/W.
  - 2 PENDING: RO; write-1-to-clear.
  - 3 OVERRUN: RO; write-1-to-clear.
  - 4 CLAIM: a read returns id and claims it; a write completes.
  - 5 STATUS: [1:0] state, [8:2+ID_W-1... ] laid out as [ID_W+1:2] in-service id.
  - Any other address reads 0; writes to it are ignored.
- Pending: edge[i] sets pending[i] regardless of ENABLE or gen. If edge[i] occurs while pending[i] is already 1, overrun[i] is set. If an edge and a W1C hit the same bit in the same cycle, the set wins.
- Id: id = (lowest index i with pending[i] & enable[i]) + 1, or 0 if there is none. Source 0 has the highest priority.
- FSM states: IDLE=0, ASSERT=1, SERVICE=2.
  - IDLE -> ASSERT when gen & |(pending & enable).
  - ASSERT -> SERVICE on a CLAIM read with id≠0. The claimed pending bit is cleared and the in-service id is latched. An edge on that same bit in the same cycle re-sets pending without flagging overrun.
  - ASSERT -> IDLE if the condition drops (mask change, W1C, gen=0).
  - SERVICE -> IDLE on a CLAIM write whose writeData[ID_W-1:0] equals the in-service id. Any other value is ignored.
  - A CLAIM read in IDLE or SERVICE returns 0 and has no side effect.
- irq is registered: irq = (next state == ASSERT). It rises 1 cycle after the edge is captured, so a src rise at edge N gives pending=1 at N, state=ASSERT at N+1, irq=1 at N+1. irq stays 0 throughout SERVICE; nesting is not supported.
- Read latency: readData is updated at the clk edge where chipSelect & read, with the value sampled before that edge's side effects. It holds that value until the next read.
- Simultaneous read & write in one cycle: the write is performed and the read is ignored.
- Width rules: writeData bits above NUM_SRC are ignored for mask/W1C. Read fields are zero-extended to 32 bits.

Test Plan:
- Reset then basic flow: set ENABLE=4'b0001, CTRL=1, raise src[0] -> PENDING=1 one cycle later, irq=1 the next cycle. Read CLAIM -> readData=1, irq=0, STATUS state=2, id=1. Write CLAIM=1 -> STATUS state=0.
- Priority: src[3] and src[1] rise together with ENABLE=4'b1111 -> CLAIM returns 2. After complete, irq reasserts and CLAIM returns 4.
- Masking/overrun: ENABLE=0, toggle src[2] twice -> PENDING=4'b0100, OVERRUN=4'b0100, irq=0. Write PENDING=4'b0100 and OVERRUN=4'b0100 -> both read 0.
- Set-wins collision: W1C PENDING bit 1 in the same cycle as a src[1] rising edge -> PENDING[1]=1.
- Wrong complete / illegal claim: in SERVICE with id=3, write CLAIM=2 -> state stays 2. Read CLAIM -> 0. Write 3 -> IDLE.
- Reset mid-service: assert rst=0 for one cycle in SERVICE -> irq=0, all registers 0. Then with src held high, PENDING=1 appears on the first post-reset cycle.

Source files
------------

// File: rtl/timer_irq_ctrl_if.sv
// Peripheral bus between the multicycle core and timer_irq_ctrl.
// Core drives the strobes; the controller returns registered readData.
interface timer_irq_ctrl_if;
  logic        chipSelect;
  logic        write;
  logic        read;
  logic [4:0]  addr;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (
    output chipSelect, write, read,
    output addr, writeData,
    input  readData
  );

  modport slave (
    input  chipSelect, write, read,
    input  addr, writeData,
    output readData
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Timer event interrupt controller: edge capture, mask,
// single irq with claim/complete over the peripheral bus.
module timer_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  timer_irq_ctrl_if.slave    bus,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [4:0] A_CTRL = 5'd0;
  localparam logic [4:0] A_EN   = 5'd1;
  localparam logic [4:0] A_PEND = 5'd2;
  localparam logic [4:0] A_OVR  = 5'd3;
  localparam logic [4:0] A_CLM  = 5'd4;
  localparam logic [4:0] A_STAT = 5'd5;

  state_t             state;
  state_t             nxt;
  logic               gen;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overrun;
  logic [NUM_SRC-1:0] prev_src;
  logic [ID_W-1:0]    svc_id;

  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] pe;
  logic [NUM_SRC-1:0] sel;
  logic [ID_W-1:0]    id;
  logic [NUM_SRC-1:0] pclr;
  logic [NUM_SRC-1:0] oclr;
  logic [NUM_SRC-1:0] cclr;
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] overrun_n;
  logic               wr;
  logic               rd;
  logic               hit;
  logic               claim;
  logic               complete;
  logic [31:0]        rdata;
  logic               unused_wd;

  assign unused_wd = ^bus.writeData;

  // A write wins over a read in the same cycle.
  assign wr = bus.chipSelect & bus.write;
  assign rd = bus.chipSelect & bus.read
            & ~bus.write;

  assign edges = src & ~prev_src;
  assign pe    = pending & enable;
  assign hit   = gen & (|pe);

  // Lowest enabled pending source wins; id is index+1.
  always_comb begin
    id  = '0;
    sel = '0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (pe[i]) begin
        id  = ID_W'(i + 1);
        sel = NUM_SRC'(1) << i;
      end
    end
  end

  assign claim = rd && (bus.addr == A_CLM)
              && (state == ASSERT)
              && (id != '0);
  assign complete = wr && (bus.addr == A_CLM)
              && (state == SERVICE)
              && (bus.writeData[ID_W-1:0] == svc_id);

  assign pclr = (wr && bus.addr == A_PEND)
              ? bus.writeData[NUM_SRC-1:0] : '0;
  assign oclr = (wr && bus.addr == A_OVR)
              ? bus.writeData[NUM_SRC-1:0] : '0;
  assign cclr = claim ? sel : '0;

  // New edges win over W1C and claim clears.
  assign pending_n = (pending & ~pclr & ~cclr)
                   | edges;
  assign overrun_n = (overrun & ~oclr)
                   | (edges & pending & ~cclr);

  // Next-state for the claim/complete handshake.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (hit) nxt = ASSERT;
      ASSERT:  if (claim) nxt = SERVICE;
               else if (!hit) nxt = IDLE;
      SERVICE: if (complete) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Read mux, sampled before this edge's side effects.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (bus.addr == A_CTRL):
        rdata = {31'b0, gen};
      (bus.addr == A_EN):
        rdata = {{(32-NUM_SRC){1'b0}}, enable};
      (bus.addr == A_PEND):
        rdata = {{(32-NUM_SRC){1'b0}}, pending};
      (bus.addr == A_OVR):
        rdata = {{(32-NUM_SRC){1'b0}}, overrun};
      (bus.addr == A_CLM):
        rdata = claim
              ? {{(32-ID_W){1'b0}}, id} : '0;
      (bus.addr == A_STAT):
        rdata = {{(30-ID_W){1'b0}}, svc_id, state};
      default: rdata = '0;
    endcase
  end

  // All state, registered irq and read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      gen          <= 1'b0;
      enable       <= '0;
      pending      <= '0;
      overrun      <= '0;
      prev_src     <= '0;
      svc_id       <= '0;
      irq          <= 1'b0;
      bus.readData <= '0;
    end else begin
      prev_src <= src;
      pending  <= pending_n;
      overrun  <= overrun_n;
      state    <= nxt;
      irq      <= (nxt == ASSERT);
      if (wr && bus.addr == A_CTRL)
        gen <= bus.writeData[0];
      if (wr && bus.addr == A_EN)
        enable <= bus.writeData[NUM_SRC-1:0];
      if (claim)
        svc_id <= id;
      else if (complete)
        svc_id <= '0;
      if (rd)
        bus.readData <= rdata;
    end
  end

endmodule
